axi_line_write_master: RTL
==========================

Name: axi_line_write_master

Overview:
- Downstream drain stage of the data-cache write buffer. Accepts one dirty 256-bit cache line plus its address, and writes it to memory as one 8-beat AXI3/AXI4 INCR burst of 32-bit beats.
- Returns a one-cycle completion pulse so the buffer can retire its head entry.
- Sits between the write buffer's memory-side port and the top-level AXI write channels.
- Uses the AW, W and B channels only.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cache-line width in bits.
- AXI_DW, 32, AXI data width. BEATS = LINE_W/AXI_DW = 8.
- AXI_ID, 4'h1, constant ID driven on awid and wid.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- wen_i  in  1  line write request. Held high by the buffer until bvalid_o.
- waddr_i  in  ADDR_W  line address. Bits [4:0] are ignored.
- wdata_i  in  LINE_W  line data. Word k is bits [32k+31:32k].
- bvalid_o  out  1  one-cycle pulse: the line is committed to memory.
- awid  out  4  = AXI_ID.
- awaddr  out  ADDR_W  {line_addr[31:5],5'b0}.
- awlen  out  8  = 7.
- awsize  out  3  = 3'b010.
- awburst  out  2  = 2'b01 (INCR).
- awlock  out  2  = 0.
- awcache  out  4  = 0.
- awprot  out  3  = 0.
- awvalid  out  1  address valid.
- awready  in  1  slave accepts the address.
- wid  out  4  = AXI_ID.
- wdata  out  AXI_DW  current beat.
- wstrb  out  4  = 4'hF.
- wlast  out  1  high on beat 7.
- wvalid  out  1  data valid.
- wready  in  1  slave accepts the beat.
- bid  in  4  ignored.
- bresp  in  2  response code.
- bvalid  in  1  response valid.
- bready  out  1  response ready.

Behaviour:
- Reset values: awvalid=0, wvalid=0, wlast=0, bready=0, bvalid_o=0, beat counter=0, state=IDLE. awaddr and wdata are don't-care until their valid is asserted.
- FSM states: IDLE, AW, W, B, DONE.
- IDLE: when wen_i=1, latch {waddr_i[31:5],5'b0} and all of wdata_i into internal registers, then go to AW. awvalid is high the next cycle (1-cycle request-to-AW latency).
- The latched copy is the data sent. Changes on wdata_i or waddr_i after acceptance have no effect (the buffer may rewrite its head during a burst). A rewritten head is re-presented by the buffer as a fresh wen_i after DONE.
- AW: hold awvalid=1 with stable awaddr until awvalid&awready. Then go to W with beat counter=0.
- W: wvalid=1. wdata = latched word[counter]. wlast = (counter==7).
  - On wvalid&wready: counter increments.
  - On the beat-7 handshake, go to B.
  - With wready low, outputs hold stable (AXI stability rule).
- W is never asserted before the AW handshake completes. No write interleaving, at most one outstanding burst.
- B: bready=1. On bvalid&bready, go to DONE.
  - Any bresp value (OKAY/EXOKAY/SLVERR/DECERR) completes the line.
  - SLVERR/DECERR is not retried and not flagged.
- DONE: bvalid_o=1 for exactly this cycle, then go to IDLE. wen_i is not sampled in DONE.
  - This matches the buffer, which drops or advances its request in the same cycle it sees bvalid_o.
  - The earliest next request is accepted in the IDLE cycle after DONE.
- Minimum occupancy per line with zero-wait slave: 1 (AW) + 8 (W) + 1 (B) + 1 (DONE) = 11 cycles after acceptance.
- wen_i dropping while busy is ignored: the accepted burst always completes.
- Reset mid-operation: next cycle all outputs return to reset values and the burst is abandoned. The memory side is reset together with the core, so the partial burst is acceptable.
- Counter is 3 bits and wraps 7→0 only on leaving W. It never wraps inside a burst.

Decomposition:
- Shared defines file (alongside the existing cache defines):
  - FSM state encoding, 3-bit.
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, LINE_BEATS=8, AWLEN_LINE=8'd7.
  - Reuse the existing WayBus and DataAddrBus width macros for wdata_i and waddr_i.
- No sub-module: beat selection is a mux indexed by the counter on the latched line register. All logic is in one module.

Test Plan:
- Single line, zero-wait slave: wen_i=1, waddr_i=32'h8000_1234, word k=32'hA0+k. Expect awaddr=32'h8000_1220, awlen=7; beats A0..A7 on 8 consecutive cycles with wlast only on A7; bvalid_o pulses once, 11 cycles after acceptance.
- Backpressure: awready delayed 3 cycles, wready toggling 1/0, bvalid delayed 5 cycles. awaddr/wdata/wlast stay stable while valid&!ready; beat order is unchanged; exactly one bvalid_o.
- Data change mid-burst: alter wdata_i to all-ones after acceptance. Memory receives the original A0..A7.
- Back-to-back: wen_i held high with a second line (B0..B7 at 32'h0000_0040) presented the cycle after bvalid_o. The second AW starts the cycle after the IDLE accept; two bvalid_o pulses total.
- SLVERR: bresp=2'b10. Still DONE, one bvalid_o, return to IDLE.
- Reset at beat 3: rst=1 for one cycle. Next cycle wvalid=awvalid=bready=bvalid_o=0, state IDLE. A new request completes normally.

Source files
------------

// File: rtl/axi_line_write_master_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_line_write_master_pkg
// Brief  : Shared widths, AXI burst constants and FSM encoding for the line drain.
// Rev    : 1.0
// ============================================================================
package axi_line_write_master_pkg;

    // Cache-side bus widths (WayBus / DataAddrBus)
    localparam int WAY_BUS_W       = 256;
    localparam int DATA_ADDR_BUS_W = 32;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam int         LINE_BEATS = 8;
    localparam logic [7:0] AWLEN_LINE = 8'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_line_write_master_if.sv
`default_nettype none
// ============================================================================
// Module : axi_line_write_master_if
// Brief  : AXI AW/W/B channel bundle between the line drain and memory.
// Rev    : 1.0
// ============================================================================
interface axi_line_write_master_if #(
    parameter int ADDR_W = 32,
    parameter int AXI_DW = 32
);
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [3:0]          wid;
    logic [AXI_DW-1:0]   wdata;
    logic [AXI_DW/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface
`default_nettype wire

// File: rtl/axi_line_write_master.sv
`default_nettype none
// ============================================================================
// Module : axi_line_write_master
// Brief  : Drains one cache line as a single 8-beat AXI INCR write burst.
// Rev    : 1.0
// ============================================================================
module axi_line_write_master
    import axi_line_write_master_pkg::*;
#(
    parameter int         ADDR_W = DATA_ADDR_BUS_W,
    parameter int         LINE_W = WAY_BUS_W,
    parameter int         AXI_DW = 32,
    parameter logic [3:0] AXI_ID = 4'h1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wen_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    input  logic [LINE_W-1:0]       wdata_i,
    output logic                    bvalid_o,
    axi_line_write_master_if.master axi
);

    localparam int BEATS = LINE_W / AXI_DW;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(BEATS - 2);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              wlast_q;
    logic              bready_q;
    logic              unused_bits;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = AWLEN_LINE;
    assign axi.awsize  = SIZE_4B;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'h0;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid_q;

    // Beat select straight off the latched line; cnt only moves on a handshake
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = line_q[AXI_DW*int'(cnt) +: AXI_DW];
    assign axi.wstrb   = {(AXI_DW/8){1'b1}};
    assign axi.wlast   = wlast_q;
    assign axi.wvalid  = wvalid_q;

    assign axi.bready  = bready_q;

    // Response ID/code and the in-line offset carry no information here
    assign unused_bits = ^{axi.bid, axi.bresp, waddr_i[OFF_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            bvalid_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wen_i) begin
                        addr_q    <= {waddr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        line_q    <= wdata_i;
                        awvalid_q <= 1'b1;
                        state     <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (axi.wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            cnt      <= '0;
                            bready_q <= 1'b1;
                            state    <= ST_B;
                        end else begin
                            cnt     <= cnt + CNT_ONE;
                            wlast_q <= (cnt == CNT_PRE_LAST);
                        end
                    end
                end
                ST_B: begin
                    // Error responses are not retried: the line is retired regardless
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        bvalid_o <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bvalid_o <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
